// File: rtl/matmul_seq_ctrl_if.sv
// ============================================================================
// Module      : matmul_seq_ctrl_if
// Description : Handshake and Matrix_Mul port bundle for matmul_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface matmul_seq_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int ADDR_W = 7
);
    logic                  in_valid;
    logic [WORD_W-1:0]     in_data;
    logic                  in_ready;
    logic                  mm_we;
    logic [ADDR_W-1:0]     mm_addr;
    logic [WORD_W-1:0]     mm_data_wr;
    logic [WORD_W-1:0]     mm_result;
    logic [3:0]            mm_qi;
    logic [3:0]            mm_qf;
    logic                  out_valid;
    logic [WORD_W+7:0]     out_data;
    logic                  out_last;
    logic                  out_ready;
    logic                  busy;

    modport master (
        input  in_valid, in_data, mm_result, mm_qi, mm_qf, out_ready,
        output in_ready, mm_we, mm_addr, mm_data_wr, out_valid, out_data, out_last, busy
    );

    modport slave (
        output in_valid, in_data, mm_result, mm_qi, mm_qf, out_ready,
        input  in_ready, mm_we, mm_addr, mm_data_wr, out_valid, out_data, out_last, busy
    );
endinterface

`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Loads a 72-word job into Matrix_Mul, waits out the compute
//               window, captures 8 results and streams them out.
//               Optional job/stall counters: define MATMUL_CTRL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matmul_seq_ctrl #(
    parameter int WORD_W         = 16,
    parameter int ADDR_W         = 7,
    parameter int MAT_WORDS      = 64,
    parameter int VEC_WORDS      = 8,
    parameter int COMPUTE_CYCLES = 70,
    parameter int RES_STRIDE     = 2
) (
    input  logic                src_clk,
    input  logic                rst,
    matmul_seq_ctrl_if.master   bus
`ifdef MATMUL_CTRL_STATS_EN
    ,
    output logic [15:0]         job_count,
    output logic [15:0]         stall_count
`endif
);

    localparam int SLOT_W  = $clog2(VEC_WORDS);
    localparam int WAIT_W  = $clog2(COMPUTE_CYCLES + 1);
    localparam int PHASE_W = $clog2(RES_STRIDE + 1);

    localparam logic [ADDR_W-1:0]  c_LAST_WORD  = ADDR_W'(MAT_WORDS + VEC_WORDS - 1);
    localparam logic [SLOT_W-1:0]  c_LAST_SLOT  = SLOT_W'(VEC_WORDS - 1);
    localparam logic [WAIT_W-1:0]  c_WAIT_END   = WAIT_W'(COMPUTE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] c_STRIDE_END = PHASE_W'(RES_STRIDE - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_WAIT    = 3'd2,
        S_CAPTURE = 3'd3,
        S_DRAIN   = 3'd4
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_widx;
    logic [WAIT_W-1:0]   r_wait_cnt;
    logic [PHASE_W-1:0]  r_phase;
    logic [SLOT_W-1:0]   r_slot;
    logic [WORD_W+7:0]   r_buf [VEC_WORDS];

    logic                r_in_ready;
    logic                r_mm_we;
    logic [ADDR_W-1:0]   r_mm_addr;
    logic [WORD_W-1:0]   r_mm_data_wr;
    logic                r_out_valid;
    logic [WORD_W+7:0]   r_out_data;
    logic                r_out_last;
    logic                r_busy;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_sample;
    logic [SLOT_W-1:0]   w_slot_nxt;

    assign w_in_fire  = bus.in_valid && r_in_ready;
    assign w_out_fire = r_out_valid && bus.out_ready;
    assign w_sample   = (r_state == S_CAPTURE) && (r_phase == '0);
    assign w_slot_nxt = r_slot + SLOT_W'(1);

    assign bus.in_ready   = r_in_ready;
    assign bus.mm_we      = r_mm_we;
    assign bus.mm_addr    = r_mm_addr;
    assign bus.mm_data_wr = r_mm_data_wr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = r_busy;

    // Result buffer carries no reset: an aborted job's slots are simply overwritten.
    always_ff @(posedge src_clk) begin
        if (w_sample) begin
            r_buf[r_slot] <= {bus.mm_qi, bus.mm_qf, bus.mm_result};
        end
    end

    always_ff @(posedge src_clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_widx       <= '0;
            r_wait_cnt   <= '0;
            r_phase      <= '0;
            r_slot       <= '0;
            r_in_ready   <= 1'b0;
            r_mm_we      <= 1'b0;
            r_mm_addr    <= '0;
            r_mm_data_wr <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_mm_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_mm_we      <= 1'b1;
                        r_mm_addr    <= '0;
                        r_mm_data_wr <= bus.in_data;
                        r_widx       <= ADDR_W'(1);
                        r_busy       <= 1'b1;
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_mm_we      <= 1'b1;
                        r_mm_addr    <= r_widx;
                        r_mm_data_wr <= bus.in_data;
                        r_widx       <= r_widx + ADDR_W'(1);
                        if (r_widx == c_LAST_WORD) begin
                            r_in_ready <= 1'b0;
                            r_wait_cnt <= '0;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == c_WAIT_END) begin
                        r_phase <= '0;
                        r_slot  <= '0;
                        r_state <= S_CAPTURE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                    end
                end
                S_CAPTURE: begin
                    r_phase <= (r_phase == c_STRIDE_END) ? '0 : r_phase + PHASE_W'(1);
                    if (w_sample) begin
                        if (r_slot == c_LAST_SLOT) begin
                            r_slot  <= '0;
                            r_state <= S_DRAIN;
                        end else begin
                            r_slot <= w_slot_nxt;
                        end
                    end
                end
                S_DRAIN: begin
                    // First DRAIN cycle only loads slot 0; the handshake starts after it.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_data  <= r_buf[r_slot];
                        r_out_last  <= (r_slot == c_LAST_SLOT);
                    end else if (bus.out_ready) begin
                        if (r_slot == c_LAST_SLOT) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_slot      <= '0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                            r_state     <= S_IDLE;
                        end else begin
                            r_slot     <= w_slot_nxt;
                            r_out_data <= r_buf[w_slot_nxt];
                            r_out_last <= (w_slot_nxt == c_LAST_SLOT);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef MATMUL_CTRL_STATS_EN
    logic r_unused_stats;
    assign r_unused_stats = 1'b0;

    always_ff @(posedge src_clk) begin
        if (rst) begin
            job_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_out_fire && (r_slot == c_LAST_SLOT)) begin
                job_count <= job_count + 16'd1;
            end
            if ((r_state == S_DRAIN) && r_out_valid && !bus.out_ready && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_matmul_seq_ctrl.sv
// ============================================================================
// Module      : tb_matmul_seq_ctrl
// Description : Self-checking bench for matmul_seq_ctrl with a job-level model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_matmul_seq_ctrl;
    localparam int WW   = 16;
    localparam int AW   = 7;
    localparam int NW   = 72;
    localparam int NR   = 8;
    localparam int MAXC = 8192;

    logic src_clk = 1'b0;
    logic rst     = 1'b1;

    matmul_seq_ctrl_if #(.WORD_W(WW), .ADDR_W(AW)) bus ();

`ifdef MATMUL_CTRL_STATS_EN
    logic [15:0] job_count;
    logic [15:0] stall_count;
`endif

    matmul_seq_ctrl #(.WORD_W(WW), .ADDR_W(AW)) dut (
        .src_clk (src_clk),
        .rst     (rst),
        .bus     (bus)
`ifdef MATMUL_CTRL_STATS_EN
        ,
        .job_count   (job_count),
        .stall_count (stall_count)
`endif
    );

    always #5 src_clk = ~src_clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [23:0] hist [MAXC];
    bit          lit_mode = 1'b1;
    int          rdy_mode = 0;
    int          rpat     = 0;

    // Job-level model: words accepted, results delivered, edge of 72nd accept.
    int          m_words = 0;
    int          m_j     = 0;
    int          m_T     = -1000;
    bit          m_rdy   = 1'b0;
    bit          m_ov    = 1'b0;
    logic [AW-1:0] m_addr = '0;
    int          m_jobs   = 0;
    int          m_stalls = 0;
    int          jobs_done = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [WW-1:0] wr_data_q [$];
    int            wr_cyc_q  [$];
    logic [23:0]   beat_q    [$];
    bit            last_q    [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Matrix_Mul result side and downstream ready, driven away from the active edge.
    always @(negedge src_clk) begin
        int idx;
        int k;
        logic [23:0] v;
        idx = cyc + 1;
        v   = 24'($urandom);
        if (lit_mode) begin
            k = idx - (m_T + 71);
            if (m_words == NW && k >= 0 && (k % 2) == 0 && (k / 2) < NR)
                v = {4'd3, 4'd5, 16'(16'h10 + k / 2)};
        end
        if (idx < MAXC) hist[idx] = v;
        bus.mm_qi     = v[23:20];
        bus.mm_qf     = v[19:16];
        bus.mm_result = v[15:0];
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (rpat % 4 == 0) || (rpat % 4 == 3);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        rpat++;
    end

    always @(posedge src_clk) begin
        bit p_rst, acc, fire, stall, e_rdy, e_ov;
        logic [WW-1:0] p_data;
        int sidx;
        cyc++;
        p_rst  = rst;
        acc    = !rst && m_rdy && bus.in_valid;
        fire   = !rst && m_ov && bus.out_ready;
        stall  = !rst && m_ov && !bus.out_ready;
        p_data = bus.in_data;
        if (bus.out_valid && bus.out_ready) begin
            beat_q.push_back(bus.out_data);
            last_q.push_back(bus.out_last);
        end
        if (p_rst) begin
            m_words = 0; m_j = 0; m_addr = '0; m_jobs = 0; m_stalls = 0; m_T = -1000;
        end else begin
            if (stall && m_stalls < 16'hFFFF) m_stalls++;
            if (fire) begin
                m_j++;
                if (m_j == NR) begin
                    m_words = 0; m_j = 0;
                    m_jobs  = (m_jobs + 1) % 65536;
                    jobs_done++;
                end
            end
            if (acc) begin
                m_addr = AW'(m_words);
                m_words++;
                if (m_words == NW) m_T = cyc;
            end
        end
        e_rdy = !p_rst && (m_words < NW);
        e_ov  = !p_rst && (m_words == NW) && (cyc >= m_T + 86);
        #1;
        chk("in_ready", bus.in_ready, e_rdy);
        chk("mm_we", bus.mm_we, acc);
        chk("mm_addr", bus.mm_addr, m_addr);
        chk("busy", bus.busy, m_words > 0);
        chk("out_valid", bus.out_valid, e_ov);
        if (acc) chk("mm_data_wr", bus.mm_data_wr, p_data);
        if (p_rst) begin
            chk("rst_data_wr", bus.mm_data_wr, 0);
            chk("rst_out_data", bus.out_data, 0);
            chk("rst_out_last", bus.out_last, 0);
        end
        if (e_ov) begin
            sidx = m_T + 71 + 2 * m_j;
            chk("out_data", bus.out_data, hist[sidx]);
            chk("out_last", bus.out_last, m_j == NR - 1);
        end
`ifdef MATMUL_CTRL_STATS_EN
        chk("job_count", job_count, m_jobs);
        chk("stall_count", stall_count, m_stalls);
`endif
        if (bus.mm_we) begin
            wr_addr_q.push_back(bus.mm_addr);
            wr_data_q.push_back(bus.mm_data_wr);
            wr_cyc_q.push_back(cyc);
        end
        m_rdy = e_rdy;
        m_ov  = e_ov;
    end

    task automatic clear_logs();
        wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
        beat_q.delete(); last_q.delete();
    endtask

    // dmode: 0 = word i, 1 = random. gmode: 0 none, 1 gap every 3rd cycle, 2 random gaps.
    task automatic send_job(input int dmode, input int gmode, input int abort_at);
        int i = 0;
        int c = 0;
        logic [WW-1:0] w;
        w = (dmode == 0) ? WW'(0) : WW'($urandom);
        while (i < NW) begin
            @(negedge src_clk);
            if (abort_at >= 0 && i == abort_at) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w;
                rst = 1'b1;
                @(negedge src_clk);
                rst = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            case (gmode)
                1:       bus.in_valid = (c % 3 != 2);
                2:       bus.in_valid = ($urandom_range(0, 9) > 2);
                default: bus.in_valid = 1'b1;
            endcase
            bus.in_data = w;
            c++;
            @(posedge src_clk);
            if (bus.in_valid && bus.in_ready) begin
                i++;
                w = (dmode == 0) ? WW'(i) : WW'($urandom);
            end
            if (c > 2000) begin
                chk("load_timeout", 32'(i), NW);
                break;
            end
        end
        @(negedge src_clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int start = jobs_done;
        int n = 0;
        while (jobs_done == start && n < 2000) begin
            @(posedge src_clk);
            n++;
        end
        if (jobs_done == start) chk("drain_timeout", 32'(jobs_done), start + 1);
        @(negedge src_clk);
    endtask

    // Literal expectations for a sequential-data, literal-result job.
    task automatic check_literal_job();
        chk("lit_nwrites", wr_addr_q.size(), NW);
        for (int i = 0; i < NW && i < wr_addr_q.size(); i++) begin
            chk("lit_wr_addr", wr_addr_q[i], i);
            chk("lit_wr_data", wr_data_q[i], i);
        end
        chk("lit_nbeats", beat_q.size(), NR);
        for (int k = 0; k < NR && k < beat_q.size(); k++) begin
            chk("lit_beat", beat_q[k], {4'd3, 4'd5, 16'(16'h10 + k)});
            chk("lit_last", last_q[k], k == NR - 1);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge src_clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_mm_we", bus.mm_we, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        @(posedge src_clk);
        #2;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);

        // Back-to-back load of 0x00..0x47, literal results.
        clear_logs();
        lit_mode = 1'b1; rdy_mode = 0;
        send_job(0, 0, -1);
        wait_done();
        check_literal_job();
        if (wr_cyc_q.size() == NW) chk("write_burst_len", wr_cyc_q[NW-1] - wr_cyc_q[0], NW - 1);

        // Downstream stalls with pattern 1,0,0,1 and random results.
        clear_logs();
        lit_mode = 1'b0; rdy_mode = 1;
        send_job(1, 0, -1);
        wait_done();
        chk("stall_nbeats", beat_q.size(), NR);

        // Input gaps every third cycle.
        clear_logs();
        lit_mode = 1'b1; rdy_mode = 0;
        send_job(0, 1, -1);
        wait_done();
        check_literal_job();

        // Fully random traffic.
        for (int j = 0; j < 3; j++) begin
            clear_logs();
            lit_mode = 1'b0; rdy_mode = 2;
            send_job(1, 2, -1);
            wait_done();
            chk("rand_nbeats", beat_q.size(), NR);
        end

        // Abort at word 30, then a clean job.
        lit_mode = 1'b1; rdy_mode = 0;
        send_job(0, 0, 30);
        clear_logs();
        send_job(0, 0, -1);
        wait_done();
        check_literal_job();
`ifdef MATMUL_CTRL_STATS_EN
        chk("lit_job_count", job_count, 1);
`endif

        repeat (4) @(negedge src_clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
